// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int MEM_LAT_DEF    = 2;
    localparam int STARVE_MAX_DEF = 3;
    localparam int CNT_W          = 3;   // holds MEM_LAT-1 for MEM_LAT up to 7
    localparam int STARVE_W       = 4;   // holds STARVE_MAX up to 15

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_src_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and shared memory port signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold xReq until the matching xValid pulse.
interface mem_port_arbiter_if;

    logic        iReq;
    logic [31:0] iAddr;
    logic        iValid;
    logic [31:0] iRdata;

    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic        dValid;
    logic [31:0] dRdata;

    logic        memEn;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;

    logic        ifStall;
    logic        memStall;

    // Requesters and memory model side.
    modport master (
        output iReq, iAddr, dReq, dWe, dAddr, dWdata, memRdata,
        input  iValid, iRdata, dValid, dRdata,
        input  memEn, memWe, memAddr, memWdata, ifStall, memStall
    );

    // Arbiter side.
    modport slave (
        input  iReq, iAddr, dReq, dWe, dAddr, dWdata, memRdata,
        output iValid, iRdata, dValid, dRdata,
        output memEn, memWe, memAddr, memWdata, ifStall, memStall
    );

endinterface

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing one memory access; flags when it has reached zero.
// Latency: load/decrement take effect on the falling edge; zero flag is combinational from the count.
// Backpressure: none; decrement is ignored once the count is zero.
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         CLK,
    input  logic         Reset_L,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load wins over decrement; count never wraps below zero.
    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, data first with starvation guard.
// Latency: grant on the falling edge a request is seen in IDLE; xValid MEM_LAT falling edges later.
// Backpressure: requesters hold xReq until xValid; ifStall/memStall flag the wait combinationally.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              CLK,
    input  logic              Reset_L,
    mem_port_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(MEM_LAT - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    gnt_src_e            w_gnt;
    logic                w_load;
    logic                w_dec;
    logic                w_done;
    logic                w_cnt_zero;

    logic [STARVE_W-1:0] r_starve_cnt;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_ivalid;
    logic                r_dvalid;
    logic [31:0]         r_irdata;
    logic [31:0]         r_drdata;

    mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
        .CLK        (CLK),
        .Reset_L    (Reset_L),
        .i_load     (w_load),
        .i_load_val (CNT_LOAD),
        .i_dec      (w_dec),
        .o_zero     (w_cnt_zero)
    );

    // State register.
    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant decision in IDLE; count down and finish the access while busy.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = GNT_NONE;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                // Data wins unless fetch is waiting and has already been passed over STARVE_MAX times.
                if (bus.dReq && !(bus.iReq && (r_starve_cnt == STARVE_LIM))) begin
                    w_gnt       = GNT_D;
                    w_state_nxt = DBUSY;
                    w_load      = 1'b1;
                end else if (bus.iReq) begin
                    w_gnt       = GNT_I;
                    w_state_nxt = IBUSY;
                    w_load      = 1'b1;
                end
            end
            IBUSY, DBUSY: begin
                if (w_cnt_zero) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory port registers, response capture and one-cycle valid pulses.
    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ivalid    <= 1'b0;
            r_dvalid    <= 1'b0;
            r_irdata    <= '0;
            r_drdata    <= '0;
        end else begin
            r_ivalid <= 1'b0;
            r_dvalid <= 1'b0;
            if (w_gnt == GNT_D) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= bus.dWe;
                r_mem_addr  <= bus.dAddr;
                r_mem_wdata <= bus.dWdata;
            end else if (w_gnt == GNT_I) begin
                r_mem_en   <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= bus.iAddr;
            end
            if (w_done) begin
                r_mem_en <= 1'b0;
                r_mem_we <= 1'b0;
                if (r_state == IBUSY) begin
                    r_ivalid <= 1'b1;
                    r_irdata <= bus.memRdata;
                end else begin
                    r_dvalid <= 1'b1;
                    // Stores leave the last loaded word in place.
                    if (!r_mem_we) begin
                        r_drdata <= bus.memRdata;
                    end
                end
            end
        end
    end

    // Count data grants that jumped ahead of a waiting fetch.
    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_starve_cnt <= '0;
        end else if (w_gnt == GNT_D) begin
            if (!bus.iReq) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != STARVE_LIM) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end else if (w_gnt == GNT_I) begin
            r_starve_cnt <= '0;
        end
    end

    assign bus.memEn    = r_mem_en;
    assign bus.memWe    = r_mem_we;
    assign bus.memAddr  = r_mem_addr;
    assign bus.memWdata = r_mem_wdata;
    assign bus.iValid   = r_ivalid;
    assign bus.iRdata   = r_irdata;
    assign bus.dValid   = r_dvalid;
    assign bus.dRdata   = r_drdata;
    assign bus.ifStall  = bus.iReq & ~r_ivalid;
    assign bus.memStall = bus.dReq & ~r_dvalid;

endmodule
